// File: rtl/pipeline_mem_pkg.sv
// Shared constants for the MEM stage: peripheral window layout and timer control bits.
package pipeline_mem_pkg;

  localparam logic [31:0] PERI_BASE_DEFAULT = 32'h4000_0000;

  localparam logic [31:0] TH_OFF   = 32'h00;
  localparam logic [31:0] TL_OFF   = 32'h04;
  localparam logic [31:0] TCON_OFF = 32'h08;
  localparam logic [31:0] LED_OFF  = 32'h0C;
  localparam logic [31:0] SW_OFF   = 32'h10;
  localparam logic [31:0] DIGI_OFF = 32'h14;
  localparam logic [31:0] TICK_OFF = 32'h18;

  localparam int TCON_EN = 0;
  localparam int TCON_IE = 1;
  localparam int TCON_ST = 2;

endpackage

// File: rtl/pipeline_mem_timer.sv
// Reloading up-counter timer (TH/TL/TCON) with a sticky overflow status and interrupt request.
module mem_timer
  import pipeline_mem_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        i_th_we,
  input  logic        i_tl_we,
  input  logic        i_tcon_we,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_th,
  output logic [31:0] o_tl,
  output logic [2:0]  o_tcon,
  output logic        o_irq
);

  logic [31:0] r_th;
  logic [31:0] r_tl;
  logic [2:0]  r_tcon;
  logic        w_ovf;
  logic        w_st_set;

  assign w_ovf    = r_tcon[TCON_EN] && (r_tl == 32'hFFFF_FFFF);
  assign w_st_set = w_ovf && r_tcon[TCON_IE];

  // Software writes take priority over counting, but a coincident overflow still sets status.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_th   <= '0;
      r_tl   <= '0;
      r_tcon <= '0;
    end else begin
      if (i_th_we) r_th <= i_wdata;

      if (i_tl_we)               r_tl <= i_wdata;
      else if (w_ovf)            r_tl <= r_th;
      else if (r_tcon[TCON_EN])  r_tl <= r_tl + 32'd1;

      if (i_tcon_we)     r_tcon <= {i_wdata[TCON_ST] | w_st_set, i_wdata[TCON_IE:TCON_EN]};
      else if (w_st_set) r_tcon[TCON_ST] <= 1'b1;
    end
  end

  assign o_th   = r_th;
  assign o_tl   = r_tl;
  assign o_tcon = r_tcon;
  assign o_irq  = r_tcon[TCON_IE] & r_tcon[TCON_ST];

endmodule

// File: rtl/pipeline_mem.sv
// MEM pipeline stage: word-addressed data RAM plus memory-mapped timer, LEDs, switches, 7-seg and systick.
module pipeline_mem
  import pipeline_mem_pkg::*;
#(
  parameter int          RAM_WORDS = 256,
  parameter logic [31:0] PERI_BASE = PERI_BASE_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] MEM_ALUOut,
  input  logic [31:0] MEM_BusB,
  input  logic        MEM_MemRead,
  input  logic        MEM_MemWrite,
  input  logic [7:0]  switch,
  output logic [31:0] MEM_ReadData,
  output logic [7:0]  led,
  output logic [11:0] digi,
  output logic        irqout
);

  localparam int IDX_W = $clog2(RAM_WORDS);

  logic [31:0]      r_ram [RAM_WORDS];
  logic [7:0]       r_led;
  logic [11:0]      r_digi;
  logic [31:0]      r_tick;

  logic             w_ram_sel;
  logic [IDX_W-1:0] w_idx;
  logic [29:0]      w_woff;
  logic             w_peri_sel;
  logic [31:0]      w_off;
  logic             w_peri_we;
  logic [31:0]      w_th;
  logic [31:0]      w_tl;
  logic [2:0]       w_tcon;
  logic             w_unused_lsb;

  // Byte lanes do not exist; only word addresses are decoded.
  assign w_unused_lsb = ^MEM_ALUOut[1:0];

  assign w_ram_sel  = (MEM_ALUOut[31:IDX_W+2] == '0);
  assign w_idx      = MEM_ALUOut[IDX_W+1:2];
  assign w_woff     = MEM_ALUOut[31:2] - PERI_BASE[31:2];
  assign w_peri_sel = !w_ram_sel && (w_woff[29:3] == '0);
  assign w_off      = {27'd0, w_woff[2:0], 2'b00};
  assign w_peri_we  = MEM_MemWrite && w_peri_sel;

  always_ff @(posedge clk) begin
    if (reset && MEM_MemWrite && w_ram_sel) r_ram[w_idx] <= MEM_BusB;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_led  <= '0;
      r_digi <= '0;
      r_tick <= '0;
    end else begin
      r_tick <= r_tick + 32'd1;
      if (w_peri_we && (w_off == LED_OFF))  r_led  <= MEM_BusB[7:0];
      if (w_peri_we && (w_off == DIGI_OFF)) r_digi <= MEM_BusB[11:0];
    end
  end

  mem_timer u_timer (
    .clk       (clk),
    .reset     (reset),
    .i_th_we   (w_peri_we && (w_off == TH_OFF)),
    .i_tl_we   (w_peri_we && (w_off == TL_OFF)),
    .i_tcon_we (w_peri_we && (w_off == TCON_OFF)),
    .i_wdata   (MEM_BusB),
    .o_th      (w_th),
    .o_tl      (w_tl),
    .o_tcon    (w_tcon),
    .o_irq     (irqout)
  );

  // Reads see register state before this cycle's write, so load+store returns the old value.
  always_comb begin
    MEM_ReadData = '0;
    if (MEM_MemRead) begin
      if (w_ram_sel) begin
        MEM_ReadData = r_ram[w_idx];
      end else if (w_peri_sel) begin
        case (w_off)
          TH_OFF:   MEM_ReadData = w_th;
          TL_OFF:   MEM_ReadData = w_tl;
          TCON_OFF: MEM_ReadData = {29'd0, w_tcon};
          LED_OFF:  MEM_ReadData = {24'd0, r_led};
          SW_OFF:   MEM_ReadData = {24'd0, switch};
          DIGI_OFF: MEM_ReadData = {20'd0, r_digi};
          TICK_OFF: MEM_ReadData = r_tick;
          default:  MEM_ReadData = '0;
        endcase
      end
    end
  end

  assign led  = r_led;
  assign digi = r_digi;

endmodule

// File: doc/pipeline_mem.md
Name: pipeline_mem

Overview:
- MEM stage of the 5-stage pipeline. Consumes the EX result (address) and store data held in the EX/MEM register, and returns load data toward MEM/WB.
- Contains the word-addressed data RAM plus the memory-mapped peripherals: timer, LEDs, switches, 7-seg digit register and system tick counter.
- Raises the timer interrupt request consumed by the control unit.

Parameters:
- RAM_WORDS, 256, data RAM depth in 32-bit words (power of two).
- PERI_BASE, 32'h40000000, peripheral window base address.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  synchronous, active-low reset
- MEM_ALUOut  input  32  byte address from EX stage ALU result
- MEM_BusB  input  32  store data (forwarded rt value)
- MEM_MemRead  input  1  load in MEM this cycle
- MEM_MemWrite  input  1  store in MEM this cycle
- switch  input  8  board switches, read-only register
- MEM_ReadData  output  32  load result, combinational from address
- led  output  8  LED register
- digi  output  12  7-seg register ({an[3:0], seg[7:0]})
- irqout  output  1  timer interrupt request

Behaviour:
- Address decode uses MEM_ALUOut[31:2]; bits [1:0] are ignored, so only word accesses exist.
- RAM region: MEM_ALUOut < RAM_WORDS*4. Index is MEM_ALUOut[log2(RAM_WORDS)+1:2].
- Peripheral offsets from PERI_BASE:
  - 0x00 TH (rw)
  - 0x04 TL (rw)
  - 0x08 TCON[2:0] (rw; bit0 enable, bit1 irq-enable, bit2 status)
  - 0x0C led (rw)
  - 0x10 switch (ro)
  - 0x14 digi (rw)
  - 0x18 systick (ro)
- Reads:
  - Combinational, zero latency: MEM_ReadData is valid in the same cycle MEM_MemRead=1.
  - MEM_MemRead=0 or unmapped address -> MEM_ReadData=0.
  - Narrow registers are zero-extended.
- Writes:
  - Take effect on the rising edge while MEM_MemWrite=1.
  - Writes to unmapped, read-only or out-of-range addresses are ignored with no side effect.
  - MEM_MemRead and MEM_MemWrite both high: the write occurs and the read returns the pre-write value.
- Reset (reset==0 at a clock edge):
  - TH=0, TL=0, TCON=0, led=0, digi=0, systick=0; irqout=0.
  - RAM contents are not reset.
  - Reset overrides any in-flight write.
- systick: increments by 1 every cycle out of reset and wraps at 2^32-1 -> 0.
- Timer, evaluated each cycle with TCON[0]=1:
  - TL != 32'hFFFFFFFF: TL <= TL+1.
  - TL == 32'hFFFFFFFF: TL <= TH; if TCON[1]=1, TCON[2] <= 1.
  - TCON[0]=0: TL holds.
- Simultaneous events:
  - A software write to TL in the same cycle as increment/reload wins; the written value is loaded.
  - A software write to TCON loads bits [1:0] as written. Bit2 becomes (written bit2) OR (overflow-set this cycle), so an overflow in the same cycle is never lost.
  - Software clears status by writing 0 to bit2.
- irqout = TCON[1] & TCON[2]; registered state, no combinational path from the bus.

Decomposition:
- Shared package holds:
  - peripheral offset constants (TH_OFF, TL_OFF, TCON_OFF, LED_OFF, SW_OFF, DIGI_OFF, TICK_OFF);
  - TCON bit indices (TCON_EN, TCON_IE, TCON_ST);
  - PERI_BASE default.
- One natural sub-module: mem_timer (TH/TL/TCON/irq logic with write-port inputs), instantiated beside the RAM and the remaining peripheral registers.

Test Plan:
- RAM write/read: store 32'hDEADBEEF at 0x10, next cycle load 0x10 -> MEM_ReadData=32'hDEADBEEF in the same cycle as MEM_MemRead; load 0x13 -> same value.
- Timer reload: TH=32'hFFFFFFFC, TL=32'hFFFFFFFE, TCON=3'b011.
  - TL sequence FFFFFFFE, FFFFFFFF, FFFFFFFC, FFFFFFFD.
  - irqout rises on the cycle after TL is FFFFFFFF.
  - Write TCON=3'b011 -> irqout=0 next cycle.
- Overflow coincident with TCON write: write TCON=3'b011 on the cycle TL==FFFFFFFF -> TCON reads 3'b111, irqout=1.
- TL write priority: enabled timer, write TL=5 -> next cycle TL=5, following cycle 6.
- Unmapped/read-only: store to 0x40000010 and to 0x00001000 -> switch readback equals input pins, RAM unchanged; load 0x40000040 -> 0.
- Reset mid-operation: running timer, led=8'hA5, then reset low one cycle with a store pending -> TL=0, TCON=0, led=0, irqout=0, systick=0 and restarting; store not performed.
